pipe_ctrl_chain: RTL and testbench

//  Parametrised multi-stage pipeline control register chain. Carries a WIDTH-bit bundle of

---
 rtl/pipe_ctrl_chain.sv | 96 +++++++++
 tb/tb_pipe_ctrl_chain.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// Purpose : DEPTH-stage control-bundle register chain (EX/MEM/WB...) with per-stage valid,
//           hold, bubble insertion, partial flush and saturating bubble/hold event counters.
// Latency : ctrl_in/valid_in reach stage 0 one cycle after capture, stage k after k+1 cycles.
// Backpr. : d_cache_miss freezes every stage; stall_en bubbles stage 0 while older stages drain.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   stall_en        load-use stall: stage 0 loads a bubble
//   flush_en        mispredict: stages 0..FLUSH_DEPTH-1 are cleared (even during a hold)
//   d_cache_miss    hold: every stage keeps its value
//   ctrl_in         control bundle from decode
//   valid_in        ctrl_in is a real instruction
//   ctrl_out        stage k at bits [k*WIDTH +: WIDTH]
//   valid_out       bit k = stage k holds a valid instruction
//   cnt_clr         synchronous clear of both counters
//   bubble_cnt      cycles in which stage 0 was bubbled by stall or flush
//   hold_cnt        cycles in which d_cache_miss froze the chain
module pipe_ctrl_chain #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_en,
    input  logic                   flush_en,
    input  logic                   d_cache_miss,
    input  logic [WIDTH-1:0]       ctrl_in,
    input  logic                   valid_in,
    output logic [DEPTH*WIDTH-1:0] ctrl_out,
    output logic [DEPTH-1:0]       valid_out,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [CNT_W-1:0]       hold_cnt
);

    // Stage 0 source: a bubble is all-zero ctrl with valid low, so a stalled
    // or invalid slot can never carry a live write enable down the pipe.
    logic             in_live;
    logic [WIDTH-1:0] in_ctrl;

    assign in_live = valid_in && !stall_en;
    assign in_ctrl = in_live ? ctrl_in : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam bit FLUSHABLE = (k < FLUSH_DEPTH);

        logic [WIDTH-1:0] ctrl_q;
        logic             vld_q;
        logic [WIDTH-1:0] src_ctrl;
        logic             src_vld;

        if (k == 0) begin : g_head
            assign src_ctrl = in_ctrl;
            assign src_vld  = in_live;
        end else begin : g_body
            assign src_ctrl = g_stage[k-1].ctrl_q;
            assign src_vld  = g_stage[k-1].vld_q;
        end

        // Flush is checked before hold: a mispredicted younger stage must die
        // even while the data cache is stalling the rest of the pipe.
        always_ff @(posedge clk) begin
            if (rst || (flush_en && FLUSHABLE)) begin
                ctrl_q <= '0;
                vld_q  <= 1'b0;
            end else if (!d_cache_miss) begin
                ctrl_q <= src_ctrl;
                vld_q  <= src_vld;
            end
        end

        assign ctrl_out[k*WIDTH +: WIDTH] = ctrl_q;
        assign valid_out[k]               = vld_q;
    end

    // Stage 0 is always in the flush range, so any flush bubbles it; a stall
    // only bubbles it when the hold is not winning.
    logic bubble_evt;

    assign bubble_evt = flush_en || (stall_en && !d_cache_miss);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (d_cache_miss && (hold_cnt != {CNT_W{1'b1}}))
                hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Purpose : directed bench for pipe_ctrl_chain; three instances share one stimulus stream:
//           default (FLUSH_DEPTH=1, CNT_W=16), a FLUSH_DEPTH=2 copy and a CNT_W=4 copy.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpr. : not applicable.
module tb_pipe_ctrl_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_en = 1'b0;
    logic        flush_en = 1'b0;
    logic        d_cache_miss = 1'b0;
    logic [7:0]  ctrl_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        cnt_clr = 1'b0;

    logic [23:0] a_ctrl, f_ctrl, c_ctrl;
    logic [2:0]  a_vld, f_vld, c_vld;
    logic [15:0] a_bub, a_hold, f_bub, f_hold;
    logic [3:0]  c_bub, c_hold;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_chain #(.WIDTH(8), .DEPTH(3), .FLUSH_DEPTH(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall_en(stall_en), .flush_en(flush_en),
        .d_cache_miss(d_cache_miss), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .ctrl_out(a_ctrl), .valid_out(a_vld), .cnt_clr(cnt_clr),
        .bubble_cnt(a_bub), .hold_cnt(a_hold)
    );

    pipe_ctrl_chain #(.WIDTH(8), .DEPTH(3), .FLUSH_DEPTH(2), .CNT_W(16)) dut_f2 (
        .clk(clk), .rst(rst), .stall_en(stall_en), .flush_en(flush_en),
        .d_cache_miss(d_cache_miss), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .ctrl_out(f_ctrl), .valid_out(f_vld), .cnt_clr(cnt_clr),
        .bubble_cnt(f_bub), .hold_cnt(f_hold)
    );

    pipe_ctrl_chain #(.WIDTH(8), .DEPTH(3), .FLUSH_DEPTH(1), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .stall_en(stall_en), .flush_en(flush_en),
        .d_cache_miss(d_cache_miss), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .ctrl_out(c_ctrl), .valid_out(c_vld), .cnt_clr(cnt_clr),
        .bubble_cnt(c_bub), .hold_cnt(c_hold)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one decode slot and advance one edge.
    task automatic issue(input logic [7:0] c, input logic v);
        ctrl_in  = c;
        valid_in = v;
        step(1);
    endtask

    initial begin
        // Reset with noisy inputs: reset must win over everything.
        rst = 1'b1; valid_in = 1'b1; ctrl_in = 8'hFF; d_cache_miss = 1'b1; stall_en = 1'b1;
        step(2);
        rst = 1'b0; valid_in = 1'b0; ctrl_in = 8'h00; d_cache_miss = 1'b0; stall_en = 1'b0;
        chk("rst_ctrl",  a_ctrl, 24'h0);
        chk("rst_valid", a_vld,  3'b000);
        chk("rst_bub",   a_bub,  16'd0);
        chk("rst_hold",  a_hold, 16'd0);

        // 1: single instruction walks the chain; trailing slot has valid_in=0
        // with garbage ctrl, which must not appear.
        issue(8'hA5, 1'b1);
        chk("t1_s0_ctrl", a_ctrl, 24'h0000A5);
        chk("t1_s0_vld",  a_vld,  3'b001);
        issue(8'hFF, 1'b0);
        chk("t1_s1_ctrl", a_ctrl, 24'h00A500);
        chk("t1_s1_vld",  a_vld,  3'b010);
        issue(8'hFF, 1'b0);
        chk("t1_s2_ctrl", a_ctrl, 24'hA50000);
        chk("t1_s2_vld",  a_vld,  3'b100);

        // 2: stall during 0x22 -> bubble in stage 0 while 0x11 advances.
        issue(8'h11, 1'b1);
        chk("t2_first", a_ctrl, 24'h000011);
        stall_en = 1'b1;
        issue(8'h22, 1'b1);
        stall_en = 1'b0;
        chk("t2_stall_ctrl", a_ctrl, 24'h001100);
        chk("t2_stall_vld",  a_vld,  3'b010);
        chk("t2_bub",        a_bub,  16'd1);

        // Refill to stages 0x33,0x22,0x11.
        issue(8'h11, 1'b1);
        issue(8'h22, 1'b1);
        issue(8'h33, 1'b1);
        chk("fill_ctrl", a_ctrl, 24'h112233);
        chk("fill_vld",  a_vld,  3'b111);

        // 3: four-cycle miss with a concurrent stall: hold wins, no bubble counted.
        valid_in = 1'b1; ctrl_in = 8'h44; d_cache_miss = 1'b1; stall_en = 1'b1;
        step(1);
        chk("t3_hold1", a_ctrl, 24'h112233);
        step(3);
        d_cache_miss = 1'b0; stall_en = 1'b0; valid_in = 1'b0;
        chk("t3_hold4_ctrl", a_ctrl, 24'h112233);
        chk("t3_hold4_vld",  a_vld,  3'b111);
        chk("t3_hold_cnt",   a_hold, 16'd4);
        chk("t3_bub_cnt",    a_bub,  16'd1);

        // 4: flush. FLUSH_DEPTH=2 clears stages 0,1; stage 2 takes pre-edge stage 1.
        flush_en = 1'b1; valid_in = 1'b1; ctrl_in = 8'h99;
        step(1);
        flush_en = 1'b0;
        chk("t4_f2_ctrl", f_ctrl, 24'h220000);
        chk("t4_f2_vld",  f_vld,  3'b100);
        chk("t4_a_ctrl",  a_ctrl, 24'h223300);
        chk("t4_a_vld",   a_vld,  3'b110);
        chk("t4_bub",     f_bub,  16'd2);

        issue(8'h44, 1'b1);
        issue(8'h55, 1'b1);
        issue(8'h66, 1'b1);
        chk("refill_a", a_ctrl, 24'h445566);
        chk("refill_f", f_ctrl, 24'h445566);

        // 5: flush during miss: flushed stages clear, the rest hold.
        flush_en = 1'b1; d_cache_miss = 1'b1; valid_in = 1'b1; ctrl_in = 8'h77;
        step(1);
        flush_en = 1'b0; d_cache_miss = 1'b0; valid_in = 1'b0;
        chk("t5_a_ctrl", a_ctrl, 24'h445500);
        chk("t5_a_vld",  a_vld,  3'b110);
        chk("t5_f_ctrl", f_ctrl, 24'h440000);
        chk("t5_f_vld",  f_vld,  3'b100);
        chk("t5_bub",    a_bub,  16'd3);
        chk("t5_hold",   a_hold, 16'd5);

        // 6: saturation on the 4-bit counters (starts at 3 bubbles).
        stall_en = 1'b1;
        step(11);
        chk("t6_c4_14", c_bub, 4'd14);
        step(9);
        chk("t6_c4_sat", c_bub, 4'd15);
        chk("t6_a_23",   a_bub, 16'd23);
        chk("t6_c4_hold", c_hold, 4'd5);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0; stall_en = 1'b0;
        chk("t6_clr_c4", c_bub,  4'd0);
        chk("t6_clr_a",  a_bub,  16'd0);
        chk("t6_clr_h",  a_hold, 16'd0);

        // Reset mid-stream with every other control asserted.
        issue(8'h81, 1'b1);
        d_cache_miss = 1'b1;
        step(1);
        chk("pre_rst_hold", a_hold, 16'd1);
        chk("pre_rst_ctrl", a_ctrl, 24'h000081);
        rst = 1'b1; stall_en = 1'b1; flush_en = 1'b1; valid_in = 1'b1; ctrl_in = 8'hC3;
        step(1);
        rst = 1'b0; stall_en = 1'b0; flush_en = 1'b0; d_cache_miss = 1'b0; valid_in = 1'b0;
        chk("mid_rst_ctrl", a_ctrl, 24'h0);
        chk("mid_rst_vld",  a_vld,  3'b000);
        chk("mid_rst_bub",  a_bub,  16'd0);
        chk("mid_rst_hold", a_hold, 16'd0);
        chk("mid_rst_f2",   f_ctrl, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
